// File: rtl/sprite_reg_update_scheduler.sv
// Queues SPI register writes and replays them into the register file only during
// vertical blanking, then strobes commit. Optional macro DEFER_STATS_EN adds deferred_frames.
module sprite_reg_update_scheduler #(
    parameter int ADDR_W           = 6,
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 8,
    parameter int WRITES_PER_BLANK = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [ADDR_W-1:0]          cmd_addr,
    input  logic [DATA_W-1:0]          cmd_data,
    input  logic                       vblank,
    output logic                       reg_we,
    output logic [ADDR_W-1:0]          reg_addr,
    output logic [DATA_W-1:0]          reg_wdata,
    output logic                       commit,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       busy
`ifdef DEFER_STATS_EN
    ,
    output logic [7:0]                 deferred_frames
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int BUD_W   = $clog2(WRITES_PER_BLANK + 1);
    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
    localparam logic [BUD_W-1:0] BUDGET_INIT = BUD_W'(WRITES_PER_BLANK);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUD_W-1:0]     budget_q, budget_d;
    logic                 applied_q, applied_d;
    logic                 vblank_q;
    logic                 reg_we_q;
    logic [ADDR_W-1:0]    reg_addr_q;
    logic [DATA_W-1:0]    reg_wdata_q;
    logic                 commit_q, commit_d;
    logic                 empty_s, full_s, push_s, pop_s, rise_s;
    logic [ENTRY_W-1:0]   head_s;

    assign empty_s = (cnt_q == {CNT_W{1'b0}});
    assign full_s  = (cnt_q == FULL_CNT);
    assign push_s  = cmd_valid && !full_s;
    assign rise_s  = vblank && !vblank_q;
    assign head_s  = mem_q[rd_ptr_q];

    assign cmd_ready = !full_s;
    assign pending   = cnt_q;
    assign busy      = (state_q == ST_DRAIN);
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign commit    = commit_q;

    // Next-state logic; the rising-edge cycle already pops with a fresh budget.
    always_comb begin
        state_d   = state_q;
        budget_d  = budget_q;
        applied_d = applied_q;
        commit_d  = 1'b0;
        pop_s     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (rise_s) begin
                    state_d   = ST_DRAIN;
                    pop_s     = !empty_s;
                    budget_d  = BUDGET_INIT - BUD_W'(pop_s);
                    applied_d = pop_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (!empty_s && (budget_q != {BUD_W{1'b0}}) && vblank) begin
                    pop_s     = 1'b1;
                    budget_d  = budget_q - BUD_W'(1);
                    applied_d = 1'b1;
                end else begin
                    state_d  = ST_HOLD;
                    commit_d = applied_q;
                end
            end
            ST_HOLD: begin
                if (!vblank) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    // Occupancy is unchanged when a push and a pop coincide.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_addr, cmd_data};
        end
    end

    // Control state, pointers and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_WAIT;
            vblank_q    <= 1'b1;
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            budget_q    <= {BUD_W{1'b0}};
            applied_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= {ADDR_W{1'b0}};
            reg_wdata_q <= {DATA_W{1'b0}};
            commit_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vblank_q  <= vblank;
            cnt_q     <= cnt_d;
            budget_q  <= budget_d;
            applied_q <= applied_d;
            commit_q  <= commit_d;
            reg_we_q  <= pop_s;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
                reg_addr_q  <= head_s[ENTRY_W-1:DATA_W];
                reg_wdata_q <= head_s[DATA_W-1:0];
            end
        end
    end

`ifdef DEFER_STATS_EN
    logic [7:0] defer_q;

    assign deferred_frames = defer_q;

    // Counts blanks that ended with work still queued, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            defer_q <= 8'd0;
        end else if ((state_q == ST_DRAIN) && (state_d == ST_HOLD) &&
                     (cnt_d != {CNT_W{1'b0}}) && (defer_q != 8'hFF)) begin
            defer_q <= defer_q + 8'd1;
        end
    end
`else
    // No deferral statistics in this build.
`endif

endmodule
